fwd_hazard_tracker: RTL
=======================

// Module: fwd_hazard_tracker
// PURPOSE
//  Next-generation forwarding/hazard block for the 5-stage RISC-V core; replaces per-stage Rd/RegWrite wiring.
//  Keeps its own record of in-flight writers (EX..last fwd stage), advanced each cycle.
//  Drives forwarding selects for NUM_SRC EX operands and a load-use stall for ID; counts stall cycles.
//  Sits beside ID/EX control; selects feed the EX operand muxes, stall_o feeds PC/IF-ID hold.
// PARAMETERS
//  REG_ADDR_W  5  register index width
//  NUM_SRC     2  source operands per instruction
//  FWD_STAGES  2  forwardable stages after EX (1=MEM, 2=WB, ...)
//  LOAD_LAT    1  extra cycles before load data is forwardable; must satisfy LOAD_LAT+1 <= FWD_STAGES
//  CNT_W       16 stall-counter width
// PORTS
//  clk_i            in   1                   clock, rising edge
//  rst_i            in   1                   reset, synchronous, active-low
//  issue_valid_i    in   1                   ID instruction moves to EX this cycle (ignored when stall_o=1)
//  issue_rd_i       in   REG_ADDR_W          its destination register
//  issue_regwrite_i in   1                   it writes rd
//  issue_memread_i  in   1                   it is a load
//  id_rs_i          in   NUM_SRC*REG_ADDR_W  ID-stage sources (load-use check)
//  id_rs_used_i     in   NUM_SRC             per-source valid mask for ID
//  ex_rs_i          in   NUM_SRC*REG_ADDR_W  EX-stage sources (forward select)
//  flush_i          in   1                   squash the instruction entering EX
//  pipe_hold_i      in   1                   global freeze (e.g. memory wait)
//  fwd_sel_o        out  NUM_SRC*SEL_W       per source: 0=regfile, k=stage k; SEL_W=$clog2(FWD_STAGES+1)
//  stall_o          out  1                   load-use stall request
//  stall_cnt_o      out  CNT_W               saturating count of stall cycles
// BEHAVIOUR
//  State: entry[0..FWD_STAGES]; entry[0]=EX, entry[k]=k stages past EX. Fields: vld, rd, is_load.
//  Entry is written with vld=1 only if regwrite=1 and rd!=0; x0 writers are never tracked.
//  Advance when pipe_hold_i=0: entry[k+1]<=entry[k], oldest entry drops.
//   entry[0] <= bubble if flush_i or stall_o or !issue_valid_i, else the issue fields. flush_i beats issue.
//  pipe_hold_i=1: every entry holds. Outputs are still computed from the held state.
//  Forward (combinational from state + ex_rs_i), per source s:
//   sel = smallest k in 1..FWD_STAGES with entry[k].vld and entry[k].rd==ex_rs[s]. Youngest writer wins.
//   No match gives 0.
//   A load in stage k < LOAD_LAT+1 never matches; stall_o guarantees this case cannot occur.
//  Stall (combinational): stall_o=1 iff, for some s, id_rs_used[s] and entry[k].vld and entry[k].is_load
//   and entry[k].rd==id_rs[s], for some k < LOAD_LAT.
//   Upstream holds ID while stall_o=1; the block inserts one bubble per stalled advance.
//  stall_cnt_o: +1 on cycles with stall_o=1 and pipe_hold_i=0. Saturates at all-ones; never wraps.
//  Reset (rst_i=0 at clk edge): all entries invalid and stall_cnt_o=0, so fwd_sel_o=0 and stall_o=0.
//   Reset mid-operation discards all in-flight tracking.
//  Latency: an issued writer is forwardable at sel=1 one advancing cycle later (zero-latency comb outputs).
// STRUCTURE
//  Package fwd_pkg: fwd_entry_t struct {vld, rd, is_load}, SEL_RF=0 constant, SEL_W function.
//  One sub-module: fwd_src_match.
//   Priority matcher: one source vs the entry array, returns sel and the load-hit flag.
//   Instantiated NUM_SRC times via generate.
//  Entry shift register and counter live in the top.
// TESTING (defaults unless noted)
//  1. Issue add x5, then ex_rs[0]=5 next cycle -> sel[0]=1; the cycle after, ex_rs[1]=5 -> sel[1]=2.
//  2. Writers of x5 in stage1 and stage2 both live, ex_rs[0]=5 -> sel[0]=1 (youngest wins).
//  3. Issue lw x7, next cycle id_rs[0]=7 used -> stall_o=1 for 1 cycle, entry[0] bubble.
//     Following cycle: stall_o=0; EX sees sel[0]=2. stall_cnt_o=1.
//  4. Issue with rd=0 or regwrite=0, then matching rs -> sel=0, stall_o=0. Unused id_rs match -> no stall.
//  5. lw x7 in EX, pipe_hold_i=1 for 3 cycles -> stall_o stays 1, entries frozen, counter unchanged.
//     flush_i with issue_valid_i=1 -> bubble enters EX.
//  6. CNT_W=4, force 20 stall cycles -> counter sticks at 15.
//     rst_i=0 mid-stream -> next cycle all outputs 0.
//  7. LOAD_LAT=2, FWD_STAGES=3: lw then dependent -> 2 stall cycles, then sel=3.

Source files
------------

// File: rtl/fwd_pkg.sv
// ============================================================================
// fwd_pkg : shared types and helpers for the forwarding/hazard tracker
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package fwd_pkg;

    // Widest register index the entry record can hold; narrower indices are zero-extended.
    localparam int RD_MAX_W = 8;

    localparam int SEL_RF = 0;

    typedef struct packed {
        logic                vld;
        logic [RD_MAX_W-1:0] rd;
        logic                is_load;
    } fwd_entry_t;

    function automatic int calc_sel_w(input int fwd_stages);
        return (fwd_stages < 1) ? 1 : $clog2(fwd_stages + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_src_match.sv
// ============================================================================
// fwd_src_match : priority matcher of one source operand against the entry array
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module fwd_src_match
    import fwd_pkg::*;
#(
    parameter  int REG_ADDR_W = 5,
    parameter  int FWD_STAGES = 2,
    parameter  int LOAD_LAT   = 1,
    localparam int SEL_W      = calc_sel_w(FWD_STAGES)
) (
    input  fwd_entry_t [FWD_STAGES:0] entries_i,
    input  logic [REG_ADDR_W-1:0]     ex_rs_i,
    input  logic [REG_ADDR_W-1:0]     id_rs_i,
    input  logic                      id_rs_used_i,
    output logic [SEL_W-1:0]          sel_o,
    output logic                      load_hit_o
);

    logic [RD_MAX_W-1:0] ex_rs_ext;
    logic [RD_MAX_W-1:0] id_rs_ext;

    assign ex_rs_ext = RD_MAX_W'(ex_rs_i);
    assign id_rs_ext = RD_MAX_W'(id_rs_i);

    // Scan oldest to youngest so the youngest matching writer is the last assignment.
    always_comb begin
        sel_o = SEL_W'(SEL_RF);
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (entries_i[k].vld && (entries_i[k].rd == ex_rs_ext) &&
                !(entries_i[k].is_load && (k < LOAD_LAT + 1))) begin
                sel_o = SEL_W'(k);
            end
        end
    end

    always_comb begin
        load_hit_o = 1'b0;
        for (int k = 0; k < LOAD_LAT; k++) begin
            if (id_rs_used_i && entries_i[k].vld && entries_i[k].is_load &&
                (entries_i[k].rd == id_rs_ext)) begin
                load_hit_o = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fwd_hazard_tracker.sv
// ============================================================================
// fwd_hazard_tracker : in-flight writer tracking, EX forwarding selects, load-use stall
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module fwd_hazard_tracker
    import fwd_pkg::*;
#(
    parameter  int REG_ADDR_W = 5,
    parameter  int NUM_SRC    = 2,
    parameter  int FWD_STAGES = 2,
    parameter  int LOAD_LAT   = 1,
    parameter  int CNT_W      = 16,
    localparam int SEL_W      = calc_sel_w(FWD_STAGES)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          issue_valid_i,
    input  logic [REG_ADDR_W-1:0]         issue_rd_i,
    input  logic                          issue_regwrite_i,
    input  logic                          issue_memread_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs_i,
    input  logic [NUM_SRC-1:0]            id_rs_used_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs_i,
    input  logic                          flush_i,
    input  logic                          pipe_hold_i,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel_o,
    output logic                          stall_o,
    output logic [CNT_W-1:0]              stall_cnt_o
);

    fwd_entry_t [FWD_STAGES:0] entries_q;
    fwd_entry_t [FWD_STAGES:0] entries_d;
    logic [CNT_W-1:0]          stall_cnt_q;
    logic [CNT_W-1:0]          stall_cnt_d;
    logic [NUM_SRC-1:0]        load_hit;
    fwd_entry_t                issue_entry;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        fwd_src_match #(
            .REG_ADDR_W (REG_ADDR_W),
            .FWD_STAGES (FWD_STAGES),
            .LOAD_LAT   (LOAD_LAT)
        ) u_match (
            .entries_i    (entries_q),
            .ex_rs_i      (ex_rs_i[s*REG_ADDR_W +: REG_ADDR_W]),
            .id_rs_i      (id_rs_i[s*REG_ADDR_W +: REG_ADDR_W]),
            .id_rs_used_i (id_rs_used_i[s]),
            .sel_o        (fwd_sel_o[s*SEL_W +: SEL_W]),
            .load_hit_o   (load_hit[s])
        );
    end

    assign stall_o     = |load_hit;
    assign stall_cnt_o = stall_cnt_q;

    // x0 writers and squashed/stalled issues enter EX as bubbles.
    always_comb begin
        issue_entry = '0;
        if (issue_valid_i && !flush_i && !stall_o && issue_regwrite_i &&
            (issue_rd_i != '0)) begin
            issue_entry.vld     = 1'b1;
            issue_entry.rd      = RD_MAX_W'(issue_rd_i);
            issue_entry.is_load = issue_memread_i;
        end
    end

    always_comb begin
        entries_d   = entries_q;
        stall_cnt_d = stall_cnt_q;
        if (!pipe_hold_i) begin
            entries_d[0] = issue_entry;
            for (int k = 1; k <= FWD_STAGES; k++) begin
                entries_d[k] = entries_q[k-1];
            end
            if (stall_o && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            entries_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            entries_q   <= entries_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

`default_nettype wire
